// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: queue entry layout, FSM states,
// special instruction encodings and the JAL immediate decoder.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
  } iq_entry_t;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] ECALL   = 32'h0000_0073;
  localparam logic [31:0] EBREAK  = 32'h0010_0073;
  localparam logic [6:0]  OPC_JAL = 7'b1101111;

  // J-type immediate: scattered imm[20|10:1|11|19:12], sign-extended, bit 0 always zero.
  function automatic logic [31:0] jal_offset(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  function automatic logic is_halt(input logic [31:0] instr);
    return (instr == ECALL) || (instr == EBREAK);
  endfunction

endpackage

// File: rtl/instr_queue.sv
// In-order instruction queue between fetch and decode. Flush only rewinds the
// pointers and count; stale storage is never visible because valid follows count.
module instr_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  iq_entry_t                wdata,
  output iq_entry_t                head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  iq_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop & valid;
  assign valid  = (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Push and pop at full leave the count unchanged; the caller guarantees no push into a full queue otherwise.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, FETCH/HALTED FSM and next-PC selection feeding instr_queue.
// Optional static JAL predictor enabled by defining FETCH_JAL_PREDICT_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [31:0]                 imem_addr,
  input  logic [31:0]                 imem_instr,
  input  logic                        redirect_valid,
  input  logic [31:0]                 redirect_pc,
  output logic                        iq_valid,
  input  logic                        iq_ready,
  output logic [31:0]                 iq_instr,
  output logic [31:0]                 iq_pc,
  output logic                        iq_pred_taken,
  output logic [$clog2(IQ_DEPTH):0]   iq_count,
  output logic                        halted
);

  localparam int CW = $clog2(IQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  seq_pc;
  logic [31:0]  target_pc;
  logic         pred;
  logic         pop;
  logic         push;
  logic         flush;
  logic         space;
  iq_entry_t    wdata;
  iq_entry_t    iq_head;
  logic [1:0]   unused_redirect_bits;

  assign unused_redirect_bits = redirect_pc[1:0];
  assign imem_addr = pc;
  assign halted    = (state == HALTED);
  assign seq_pc    = pc + 32'd4;
  assign pop       = iq_valid & iq_ready;
  assign space     = (iq_count < DEPTH_C) | pop;

`ifdef FETCH_JAL_PREDICT_EN
  assign pred      = (imem_instr[6:0] == OPC_JAL);
  assign target_pc = pred ? (pc + jal_offset(imem_instr)) : seq_pc;
`else
  assign pred      = 1'b0;
  assign target_pc = seq_pc;
`endif

  assign wdata.pc         = pc;
  assign wdata.instr      = imem_instr;
  assign wdata.pred_taken = pred;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  // Redirect beats everything; a halting instruction is still enqueued before fetch stops.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_n    = {redirect_pc[31:2], 2'b00};
      state_n = FETCH;
    end else if (state == FETCH && space) begin
      push = 1'b1;
      if (is_halt(imem_instr)) begin
        state_n = HALTED;
        pc_n    = seq_pc;
      end else begin
        pc_n    = target_pc;
      end
    end
  end

  instr_queue #(
    .DEPTH(IQ_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (iq_head),
    .valid (iq_valid),
    .count (iq_count)
  );

  assign iq_instr = iq_head.instr;
  assign iq_pc    = iq_head.pc;

`ifdef FETCH_JAL_PREDICT_EN
  assign iq_pred_taken = iq_valid & iq_head.pred_taken;
`else
  logic unused_head_pred;
  assign unused_head_pred = iq_head.pred_taken;
  assign iq_pred_taken    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized ready/redirect/reset
// traffic, compared each cycle against a queue-based reference model of the fetch stage.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] ECALL_W  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iq_valid;
  logic        iq_ready;
  logic [31:0] iq_instr;
  logic [31:0] iq_pc;
  logic        iq_pred_taken;
  logic [2:0]  iq_count;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Program image for the low 256 bytes; everything else reads an address-tagged ADDI.
  logic [31:0] prog   [64];
  bit          is_jal [64];
  int          jal_off[64];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;

`ifdef FETCH_JAL_PREDICT_EN
  localparam bit PRED_ON = 1'b1;
`else
  localparam bit PRED_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC(RESET_PC),
    .IQ_DEPTH(DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .iq_valid       (iq_valid),
    .iq_ready       (iq_ready),
    .iq_instr       (iq_instr),
    .iq_pc          (iq_pc),
    .iq_pred_taken  (iq_pred_taken),
    .iq_count       (iq_count),
    .halted         (halted)
  );

  function automatic logic [31:0] addi_word(input logic [31:0] a);
    return {a[13:2], 5'd1, 3'b000, 5'd1, 7'h13};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd256) return prog[a[7:2]];
    return addi_word(a);
  endfunction

  function automatic logic [31:0] jal_word(input int off);
    logic [20:0] imm;
    imm = 21'(off);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd2, 7'b1101111};
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  task automatic load_default_prog();
    for (int i = 0; i < 64; i++) begin
      prog[i]    = addi_word(32'(i * 4));
      is_jal[i]  = 1'b0;
      jal_off[i] = 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the reference model, from the rules for reset, redirect, pop and fetch.
  task automatic model_step(input logic r, input logic rdy, input logic rv, input logic [31:0] rp);
    bit          do_pop;
    bit          has_space;
    exp_t        e;
    logic [31:0] w;
    logic [31:0] nxt;
    if (r) begin
      mq.delete();
      m_pc   = RESET_PC;
      m_halt = 1'b0;
    end else if (rv) begin
      mq.delete();
      m_pc   = rp & 32'hFFFF_FFFC;
      m_halt = 1'b0;
    end else begin
      do_pop    = (mq.size() > 0) && rdy;
      has_space = (mq.size() < DEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (!m_halt && has_space) begin
        w       = mem_word(m_pc);
        e.pc    = m_pc;
        e.instr = w;
        e.pred  = 1'b0;
        nxt     = m_pc + 32'd4;
        if (w == ECALL_W || w == EBREAK_W) begin
          m_halt = 1'b1;
        end else if (PRED_ON && m_pc < 32'd256 && is_jal[m_pc[7:2]]) begin
          e.pred = 1'b1;
          nxt    = m_pc + 32'(jal_off[m_pc[7:2]]);
        end
        mq.push_back(e);
        m_pc = nxt;
      end
    end
  endtask

  task automatic check_state();
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("iq_count", 32'(iq_count), 32'(mq.size()));
    checkOutput("iq_valid", 32'(iq_valid), 32'(mq.size() > 0));
    checkOutput("halted", 32'(halted), 32'(m_halt));
    if (mq.size() > 0 && iq_valid) begin
      checkOutput("iq_pc", iq_pc, mq[0].pc);
      checkOutput("iq_instr", iq_instr, mq[0].instr);
      checkOutput("iq_pred_taken", 32'(iq_pred_taken), 32'(mq[0].pred));
    end
  endtask

  // Called at a falling edge: drive inputs, advance the model, then check at the next falling edge.
  task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] rp);
    rst            = r;
    iq_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rp;
    model_step(r, rdy, rv, rp);
    @(negedge clk);
    check_state();
  endtask

  initial begin
    rst            = 1'b1;
    iq_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    m_pc           = RESET_PC;
    m_halt         = 1'b0;
    load_default_prog();
    @(negedge clk);

    // Reset state, then saturation with the consumer stalled.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("rst_valid", 32'(iq_valid), 0);
    checkOutput("rst_count", 32'(iq_count), 0);
    checkOutput("rst_pred", 32'(iq_pred_taken), 0);
    checkOutput("rst_halted", 32'(halted), 0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0);
    checkOutput("sat_count", 32'(iq_count), 4);
    checkOutput("sat_addr", imem_addr, 32'h10);
    checkOutput("sat_head", iq_pc, 32'h0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);

    // Streaming with ready held high.
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 0);
      checkOutput("stream_le1", 32'(iq_count <= 3'd1), 1);
    end

    // Redirect with three entries queued, aligned and unaligned targets.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 1, (k == 0) ? 32'h40 : 32'h43);
      checkOutput("redir_valid", 32'(iq_valid), 0);
      checkOutput("redir_count", 32'(iq_count), 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("redir_head", iq_pc, 32'h40);
    end

    // ECALL at address 8 halts fetch; redirect restarts it.
    prog[2] = ECALL_W;
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 0, 0);
    checkOutput("ecall_halted", 32'(halted), 1);
    checkOutput("ecall_count", 32'(iq_count), 0);
    checkOutput("ecall_addr", imem_addr, 32'hC);
    applyStimulus(0, 1, 1, 32'h0);
    checkOutput("ecall_resume", 32'(halted), 0);
    prog[2] = addi_word(32'h8);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0);

    // PC wrap at the top of the address space.
    applyStimulus(0, 1, 1, 32'hFFFF_FFFC);
    checkOutput("wrap_top", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 1, 0, 0);
    checkOutput("wrap_zero", imem_addr, 32'h0);
    applyStimulus(0, 1, 0, 0);

    // JAL +16 at address 4.
    prog[1]    = jal_word(16);
    is_jal[1]  = 1'b1;
    jal_off[1] = 16;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("jal_next_addr", imem_addr, PRED_ON ? 32'd20 : 32'd8);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("jal_head_pc", iq_pc, 32'd4);
    checkOutput("jal_pred", 32'(iq_pred_taken), 32'(PRED_ON));
    applyStimulus(0, 1, 0, 0);
    checkOutput("jal_follow_pc", iq_pc, PRED_ON ? 32'd20 : 32'd8);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 0);

    // Randomized program and traffic.
    for (int i = 0; i < 64; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      prog[i]    = addi_word(32'(i * 4));
      is_jal[i]  = 1'b0;
      jal_off[i] = 0;
      if (r == 0) prog[i] = ECALL_W;
      else if (r == 1) prog[i] = EBREAK_W;
      else if (r <= 4) begin
        jal_off[i] = (int'($urandom_range(0, 16)) - 8) * 4;
        prog[i]    = jal_word(jal_off[i]);
        is_jal[i]  = 1'b1;
      end
    end
    applyStimulus(1, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic        r_rst;
      logic        r_rdy;
      logic        r_rv;
      logic [31:0] r_pc;
      r_rst = ($urandom % 64) == 0;
      r_rdy = ($urandom % 4) != 0;
      r_rv  = ($urandom % 12) == 0;
      r_pc  = (($urandom % 8) == 0) ? $urandom : 32'($urandom_range(0, 255));
      applyStimulus(r_rst, r_rdy, r_rv, r_pc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Front-end fetch stage of the Tomasulo core. Holds the program counter, drives a word address to the combinational instruction memory, and captures each returned instruction with its PC into a small in-order instruction queue. Decode/dispatch consumes the queue over a valid/ready handshake. The commit/branch unit redirects fetch on mispredict or exception, which flushes the queue.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; low 2 bits must be 0.
- `IQ_DEPTH`, default 4: instruction-queue entries; power of two, ≥2.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset (one clock; synchronous active-high reset, per the fixed decision).
- `imem_addr` out 32: byte address to instruction memory, equals current PC.
- `imem_instr` in 32: instruction word returned combinationally for `imem_addr`.
- `redirect_valid` in 1: flush queue and restart fetch this cycle.
- `redirect_pc` in 32: new PC; bits [1:0] ignored (forced 0).
- `iq_valid` out 1: queue head valid.
- `iq_ready` in 1: consumer accepts head when `iq_valid & iq_ready`.
- `iq_instr` out 32: head instruction.
- `iq_pc` out 32: head PC.
- `iq_pred_taken` out 1: head was predicted taken by fetch.
- `iq_count` out $clog2(IQ_DEPTH)+1: current occupancy.
- `halted` out 1: fetch stopped on ECALL/EBREAK.

## Operation
- FSM states: FETCH, HALTED. Reset → FETCH.
- FETCH: enqueue {pc, imem_instr, pred} when there is space (`iq_count < IQ_DEPTH`, or a pop occurs the same cycle); then pc ← next_pc. No space → pc holds, memory re-read next cycle.
- next_pc = pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0), except with predict enabled (see Configuration).
- Fetched word equal to 32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK): enqueue it, pc ← pc + 4, go to HALTED. HALTED: no enqueue, pc holds, `halted` = 1.
- `redirect_valid` has priority over every other event:
  - all entries are discarded;
  - pc ← {redirect_pc[31:2], 2'b00};
  - state ← FETCH;
  - no enqueue that cycle.
  - A pop handshaked in the same cycle counts as consumed.
- Pop: head leaves on `iq_valid & iq_ready`. Simultaneous push and pop at full: both occur, count unchanged.
- Queue order strictly FIFO; pointers wrap modulo IQ_DEPTH.
- `iq_instr`, `iq_pc`, `iq_pred_taken` are don't-care when `iq_valid` = 0; the bench checks them only when valid.

## Timing
- Reset values:
  - pc = RESET_PC, so `imem_addr` = RESET_PC;
  - `iq_valid` = 0, `iq_count` = 0, `iq_pred_taken` = 0;
  - `halted` = 0, state FETCH.
- Queue outputs are registered. An instruction fetched in cycle N appears at the head no earlier than cycle N+1.
- First instruction after reset release: fetched in cycle 0, `iq_valid` = 1 in cycle 1.
- Redirect asserted in cycle N:
  - `iq_valid` = 0 in N+1;
  - redirect target fetched in N+1;
  - target visible at the head in N+2.
- `rst` asserted mid-operation: full reset state next cycle; queue contents lost.
- Steady state with `iq_ready` held at 1: one instruction per cycle.
- No combinational path from `iq_ready` or `redirect_valid` to `iq_valid`.

## Configuration
- `FETCH_JAL_PREDICT_EN` defined:
  - a fetched JAL (opcode 7'b1101111) sets next_pc = pc + sext({imm[20:1],1'b0}) and enqueues with pred = 1;
  - all other instructions use pred = 0.
- Not defined: next_pc is always pc + 4 and `iq_pred_taken` is tied to 0.

## Structure
- `fetch_pkg` holds:
  - `iq_entry_t` struct {pc, instr, pred_taken};
  - `fetch_state_t` enum {FETCH, HALTED};
  - constants: NOP 32'h0000_0013, ECALL, EBREAK, OPC_JAL.
- Sub-module `instr_queue`: a synchronous FIFO of `iq_entry_t` with push, pop, flush and count. The flush clears the pointers only.
- `instr_fetch` contains the PC, the FSM, next-PC logic and the JAL predictor.

## Test plan
- Reset with RESET_PC = 0, `iq_ready` = 1, memory holding ADDI words:
  - cycle 1 head pc = 0;
  - consecutive cycles give pc 4, 8, 12, each with the correct instr;
  - `iq_count` stays ≤ 1.
- `iq_ready` = 0 for 10 cycles:
  - `iq_count` saturates at 4 with heads 0, 4, 8, 12;
  - `imem_addr` holds at 16;
  - on release, entries drain in order, followed by pc 16.
- Redirect to 32'h40 (and 32'h43) while the queue holds 3 entries:
  - next cycle `iq_valid` = 0, `iq_count` = 0;
  - two cycles later head pc = 32'h40 in both cases.
- ECALL at address 8:
  - entries 0, 4, 8 are delivered, then `halted` = 1 and nothing further is enqueued;
  - redirect to 0 clears `halted` and restarts fetch.
- PC wrap: redirect to 32'hFFFF_FFFC, then the next fetch address is 0.
- With `FETCH_JAL_PREDICT_EN`, JAL +16 at address 4:
  - head pc 4 has `iq_pred_taken` = 1;
  - the following head pc = 20.
- Without the macro, the same JAL is followed by pc 8 and `iq_pred_taken` = 0.
